// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver.
//
// Synchronizes and deglitches the raw keyboard clock/data lines, deserializes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and presents each
// good byte on `key` for one cycle. A partial frame with no clock activity for
// TIMEOUT_CYCLES is abandoned.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   ps2_clk    raw keyboard clock (asynchronous, idles high)
//   ps2_data   raw keyboard data (asynchronous, idles high)
//   key        received byte for one cycle per good frame, 8'h00 otherwise
//   key_valid  high in the cycle `key` carries a byte
//   frame_err  one-cycle pulse on parity, stop-bit or timeout error

module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       frame_err
);

    localparam logic [7:0]  FiltMax = 8'(FILTER_LEN - 1);
    localparam logic [19:0] ToMax   = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    // Two-flop synchronizers, reset to the idle (high) line level.
    logic clk_meta_q, clk_sync_q;
    logic dat_meta_q, dat_sync_q;

    // Glitch filter.
    logic [7:0] filt_cnt_q, filt_cnt_d;
    logic       filt_clk_q, filt_clk_d;
    logic       fall;

    // Frame deserializer.
    state_e      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_q, par_d;
    logic [19:0] to_cnt_q, to_cnt_d;

    // Registered outputs.
    logic [7:0] key_q, key_d;
    logic       key_valid_q, key_valid_d;
    logic       frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            state_q     <= StIdle;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            dat_meta_q  <= ps2_data;
            dat_sync_q  <= dat_meta_q;
            filt_cnt_q  <= filt_cnt_d;
            filt_clk_q  <= filt_clk_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The filtered clock follows the synchronized clock only after the new level
    // has been seen for FILTER_LEN consecutive cycles; `fall` is asserted in the
    // cycle the filtered clock drops, which is when data is sampled.
    always_comb begin
        filt_cnt_d = '0;
        filt_clk_d = filt_clk_q;
        fall       = 1'b0;
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FiltMax) begin
                filt_clk_d = clk_sync_q;
                fall       = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        key_d       = '0;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
        to_cnt_d    = (state_q == StIdle || fall) ? '0 : to_cnt_q + 20'd1;

        // A clock edge takes priority over a coincident timeout.
        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    // A high level here is a spurious edge, not a start bit.
                    if (!dat_sync_q) begin
                        state_d  = StData;
                        bitcnt_d = '0;
                        shreg_d  = '0;
                    end
                end
                StData: begin
                    shreg_d[bitcnt_q] = dat_sync_q;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                StParity: begin
                    par_d   = dat_sync_q;
                    state_d = StStop;
                end
                StStop: begin
                    if (dat_sync_q && (^{shreg_q, par_q})) begin
                        key_d       = shreg_q;
                        key_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && to_cnt_q == ToMax) begin
            state_d     = StIdle;
            shreg_d     = '0;
            frame_err_d = 1'b1;
        end
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: randomized scoreboard bench for ps2_rx.
//
// Stimulus tasks emit PS/2 frames on the raw lines and push the outcome the
// protocol dictates (byte or error) into a queue; an independent monitor pops
// and compares whenever the DUT strobes key_valid or frame_err.

module tb_ps2_rx;

    localparam int unsigned FiltLen = 4;
    localparam int unsigned ToCyc   = 500;
    localparam int          Half    = 40;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key;
    logic       key_valid;
    logic       frame_err;

    ps2_rx #(
        .FILTER_LEN    (FiltLen),
        .TIMEOUT_CYCLES(ToCyc)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key      (key),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [7:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    int   last_out_cyc = -1000000;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("exclusive", int'(key_valid & frame_err), 0);
            if (!key_valid) check("key_idle_zero", int'(key), 0);
            if (key_valid || frame_err) begin
                last_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'({frame_err, key}), 'h1ff);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_err", int'(frame_err), int'(e.err));
                    check("out_key", int'(key_valid ? key : 8'h00), int'(e.err ? 8'h00 : e.b));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference outcome of a full frame: good when stop is high and the nine
    // data+parity bits hold an odd number of ones.
    function automatic exp_t frame_outcome(input logic [7:0] b, input logic par,
                                           input logic stop);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        ones += int'(par);
        e.err = !(stop && (ones % 2 == 1));
        e.b   = b;
        return e;
    endfunction

    // Sends the first n bits of `bits` (bit 0 first). Data changes mid-high,
    // the device-side convention. glitch_at >= 0 inserts a 3-cycle high pulse
    // in that bit's low phase.
    task automatic send_bits(input logic [10:0] bits, input int n, input int half,
                             input int glitch_at);
        for (int i = 0; i < n; i++) begin
            cycles(half / 2);
            ps2_data = bits[i];
            cycles(half - half / 2);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (i == glitch_at) begin
                cycles(half / 2);
                ps2_clk = 1'b1;
                cycles(3);
                ps2_clk = 1'b0;
                cycles(half - half / 2 - 3);
            end else begin
                cycles(half);
            end
            ps2_clk = 1'b1;
        end
        cycles(half / 2);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int half, input int glitch_at);
        exp_q.push_back(frame_outcome(b, par, stop));
        send_bits({stop, par, b, 1'b0}, 11, half, glitch_at);
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    initial begin
        logic [7:0] b;
        logic       par;
        logic       stop;
        int         half;

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        #1;
        check("rst_key", int'(key), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_err", int'(frame_err), 0);
        cycles(5);
        rst_n = 1'b1;
        cycles(20);

        // 1: single good frame; output 2 sync + FILTER_LEN cycles after the raw
        // stop-bit fall (fall cycle plus one register stage).
        send_frame(8'h1C, 1'b0, 1'b1, Half, -1);
        cycles(10);
        check("latency_key", last_out_cyc - last_fall_cyc, int'(FiltLen) + 2);

        // 2: back-to-back F0 then 1C.
        send_frame(8'hF0, 1'b1, 1'b1, Half, -1);
        send_frame(8'h1C, 1'b0, 1'b1, Half, -1);
        cycles(20);

        // 3: bad parity then good 1B.
        send_frame(8'h1C, 1'b1, 1'b1, Half, -1);
        send_frame(8'h1B, odd_par(8'h1B), 1'b1, Half, -1);
        cycles(20);

        // 4: start + 3 data bits then a stall; the timeout fires TIMEOUT_CYCLES
        // after the filtered fall, itself 2 + FILTER_LEN after the raw one.
        exp_q.push_back('{err: 1'b1, b: 8'h00});
        send_bits({7'h7f, 4'b0000}, 4, Half, -1);
        cycles(600);
        check("latency_timeout", last_out_cyc - last_fall_cyc, int'(ToCyc + FiltLen) + 2);
        send_frame(8'hF0, 1'b1, 1'b1, Half, -1);
        cycles(20);

        // 5: low glitch in idle, high glitch inside a frame.
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(30);
        send_frame(8'h1C, 1'b0, 1'b1, Half, 4);
        cycles(20);

        // 6: reset after 5 data bits, then E0.
        send_bits({5'h1f, 6'b001100}, 6, Half, -1);
        rst_n = 1'b0;
        #1;
        check("midrst_key", int'(key), 0);
        check("midrst_valid", int'(key_valid), 0);
        check("midrst_err", int'(frame_err), 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(20);
        send_frame(8'hE0, odd_par(8'hE0), 1'b1, Half, -1);
        cycles(20);

        // Random frames: random byte, occasional parity/stop corruption,
        // random bit period and inter-frame gap.
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom_range(0, 255));
            par  = odd_par(b) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 7) != 0);
            half = int'($urandom_range(30, 50));
            send_frame(b, par, stop, half, -1);
            cycles(int'($urandom_range(0, 20)));
        end

        cycles(40);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
